// File: rtl/dsa_out_streamer.sv
// Readback streamer for the DSA result image: reads mem_out row-major and emits
// a valid/ready byte stream with a last-beat marker and a running 16-bit checksum.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | pixel count latched, first read may issue
// STREAM | reads issued and FIFO drained to the sink
// DONE   | one-cycle done pulse
module dsa_out_streamer #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk_50,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   out_w,
  input  logic [15:0]   out_h,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic [15:0]   checksum,
  output logic          err_size
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};

  state_t        r_state;
  state_t        w_next;
  logic [AW:0]   r_rem;
  logic [AW-1:0] r_addr;
  logic          r_inflight;
  logic          r_inflight_last;
  logic [DW-1:0] r_fifo_data [3];
  logic          r_fifo_last [3];
  logic [1:0]    r_wp;
  logic [1:0]    r_rp;
  logic [1:0]    r_cnt;
  logic [15:0]   r_cs;
  logic          r_err;

  logic [31:0]   w_prod;
  logic          w_big;
  logic [AW:0]   w_n;
  logic          w_start_acc;
  logic          w_pop;
  logic          w_head_last;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_prod      = {16'd0, out_w} * {16'd0, out_h};
  assign w_big       = w_prod > {{(31-AW){1'b0}}, CAP};
  assign w_n         = w_big ? CAP : w_prod[AW:0];
  assign w_start_acc = start && (r_state == S_IDLE);

  assign m_valid     = (r_cnt != 2'd0);
  assign w_head_last = r_fifo_last[r_rp];
  assign m_data      = m_valid ? r_fifo_data[r_rp] : '0;
  assign m_last      = m_valid && w_head_last;
  assign w_pop       = m_valid && m_ready;

  assign rd_addr     = r_addr;
  assign checksum    = r_cs;
  assign err_size    = r_err;

  always_ff @(posedge clk_50) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   w_next = (r_rem == '0) ? S_DONE : S_STREAM;
      S_STREAM: if (w_pop && w_head_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Occupancy plus the read still in flight must stay below the FIFO depth.
  always_comb begin
    rd_en = 1'b0;
    busy  = (r_state != S_IDLE);
    done  = (r_state == S_DONE);
    if ((r_state == S_LOAD) || (r_state == S_STREAM))
      rd_en = (r_rem != '0) && (({1'b0, r_cnt} + {2'b0, r_inflight}) < 3'd3);
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_rem           <= '0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wp            <= 2'd0;
      r_rp            <= 2'd0;
      r_cnt           <= 2'd0;
      r_cs            <= 16'd0;
      r_err           <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_start_acc) begin
        r_rem  <= w_n;
        r_addr <= '0;
        r_err  <= w_big;
      end else if (rd_en) begin
        r_rem  <= r_rem - 1'b1;
        r_addr <= r_addr + 1'b1;
      end

      r_inflight      <= rd_en;
      r_inflight_last <= rd_en && (r_rem == (AW+1)'(1));

      if (r_inflight) begin
        r_fifo_data[r_wp] <= rd_data;
        r_fifo_last[r_wp] <= r_inflight_last;
        r_wp              <= ptr_inc(r_wp);
      end

      if (w_start_acc)
        r_cs <= 16'd0;
      else if (w_pop)
        r_cs <= r_cs + 16'(m_data);

      if (w_pop) r_rp <= ptr_inc(r_rp);

      case ({r_inflight, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dsa_out_streamer.sv
// Bench for dsa_out_streamer: behavioural mem_out model, randomized images and
// sink backpressure, checked against an image/checksum model built from the rules.
module tb_dsa_out_streamer;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk_50 = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   out_w;
  logic [15:0]   out_h;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic [15:0]   checksum;
  logic          err_size;

  dsa_out_streamer #(.AW(AW), .DW(DW)) dut (
    .clk_50(clk_50), .rst(rst), .start(start), .out_w(out_w), .out_h(out_h),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .checksum(checksum), .err_size(err_size)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mem_model [0:4095];
  int cyc = 0;
  int t0 = 0;
  bit mon_on = 1'b0;
  int exp_n, beats, rd_cnt, nxt_addr, first_rd, first_vld, done_rel, viol;
  bit done_seen;
  bit prev_hold;
  logic [7:0] prev_data;
  logic prev_last;
  int rmode = 0;

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;
  always @(posedge clk_50) if (rd_en) rd_data <= mem_model[rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk_50);
      #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk_50) if (mon_on) begin
    if (rd_cnt - beats > 3) viol++;
    if (prev_hold)
      chk("hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_last, prev_data}));
    if (rd_en) begin
      if (first_rd < 0) first_rd = cyc - t0;
      chk("rd_addr", 32'(rd_addr), 32'(nxt_addr));
      if (nxt_addr >= exp_n) viol++;
      nxt_addr++;
      rd_cnt++;
    end
    if (m_valid && first_vld < 0) first_vld = cyc - t0;
    if (m_valid && m_ready) begin
      if (beats < exp_n) begin
        chk("data", 32'(m_data), 32'(mem_model[12'(beats)]));
        chk("last", 32'(m_last), 32'(beats == exp_n - 1));
      end else viol++;
      beats++;
    end
    prev_hold = m_valid && !m_ready;
    prev_data = m_data;
    prev_last = m_last;
    if (done) begin
      if (!done_seen) done_rel = cyc - t0;
      done_seen = 1'b1;
      chk("busy_at_done", 32'(busy), 32'd1);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"},    32'(rd_en),    32'd0);
    chk({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
    chk({tag, "_m_valid"},  32'(m_valid),  32'd0);
    chk({tag, "_m_data"},   32'(m_data),   32'd0);
    chk({tag, "_m_last"},   32'(m_last),   32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
    chk({tag, "_err_size"}, 32'(err_size), 32'd0);
  endtask

  task automatic arm_monitor(input int n);
    exp_n = n; beats = 0; rd_cnt = 0; nxt_addr = 0; first_rd = -1; first_vld = -1;
    done_rel = -1; viol = 0; done_seen = 1'b0; prev_hold = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic pulse_start(input int w, input int h);
    out_w = 16'(w);
    out_h = 16'(h);
    @(posedge clk_50); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk_50); #1;
    start = 1'b0;
  endtask

  // fill: 0 = mem[i]=i, 1 = all 0xFF, 2 = random; mode: 0 ready=1, 1 toggle, 2 random
  task automatic run_test(input int w, input int h, input int fill, input int mode);
    longint p;
    int n;
    bit big;
    logic [15:0] cs;
    int budget;
    p = longint'(w) * longint'(h);
    big = (p > 4096);
    n = big ? 4096 : int'(p);
    for (int i = 0; i < 4096; i++)
      mem_model[i] = (fill == 0) ? 8'(i) : (fill == 1) ? 8'hFF : 8'($urandom);
    cs = 16'd0;
    for (int i = 0; i < n; i++) cs = cs + 16'(mem_model[i]);
    rmode = mode;
    arm_monitor(n);
    pulse_start(w, h);
    budget = 4 * n + 40;
    for (int k = 0; k < budget && !done_seen; k++) @(posedge clk_50);
    chk("done_seen", 32'(done_seen), 32'd1);
    @(negedge clk_50); #1;
    mon_on = 1'b0;
    chk("beats",     32'(beats),    32'(n));
    chk("reads",     32'(rd_cnt),   32'(n));
    chk("checksum",  32'(checksum), 32'(cs));
    chk("err_size",  32'(err_size), 32'(big));
    chk("busy_after", 32'(busy),    32'd0);
    chk("done_after", 32'(done),    32'd0);
    chk("violations", 32'(viol),    32'd0);
    if (mode == 0) begin
      if (n > 0) begin
        chk("first_rd_cyc",  32'(first_rd),  32'd1);
        chk("first_vld_cyc", 32'(first_vld), 32'd3);
        chk("done_cyc",      32'(done_rel),  32'(n + 3));
      end else begin
        chk("done_cyc_n0",  32'(done_rel),  32'd2);
        chk("no_rd_en_n0",  32'(first_rd),  32'hFFFF_FFFF);
        chk("no_valid_n0",  32'(first_vld), 32'hFFFF_FFFF);
      end
    end
  endtask

  task automatic reset_mid();
    for (int i = 0; i < 4096; i++) mem_model[i] = 8'(i);
    rmode = 0;
    arm_monitor(100);
    pulse_start(10, 10);
    for (int k = 0; k < 200 && beats < 20; k++) @(posedge clk_50);
    #1;
    start = 1'b1;
    out_w = 16'd5;
    out_h = 16'd5;
    @(posedge clk_50); #1;
    start = 1'b0;
    out_w = 16'd10;
    out_h = 16'd10;
    for (int k = 0; k < 200 && beats < 40; k++) @(posedge clk_50);
    chk("beats_reached_40", 32'(beats >= 40), 32'd1);
    chk("busy_mid", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    @(posedge clk_50); #1;
    mon_on = 1'b0;
    chk_reset_vals("midrst");
    @(posedge clk_50); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_w = 16'd0;
    out_h = 16'd0;
    repeat (3) @(posedge clk_50);
    #1;
    chk_reset_vals("por");
    rst = 1'b0;

    run_test(10, 10, 0, 0);
    run_test(10, 10, 0, 1);
    run_test(0, 10, 0, 0);
    run_test(100, 100, 0, 0);
    run_test(8, 8, 1, 0);
    run_test(300, 300, 2, 2);
    for (int t = 0; t < 6; t++)
      run_test(int'($urandom_range(0, 24)), int'($urandom_range(1, 24)), 2, 2);
    reset_mid();
    run_test(10, 10, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsa_out_streamer.md
# dsa_out_streamer

Downstream readback stage of the bilinear DSA (`top_dsa_seq`). On a start pulse, normally the selected core's `done`, it reads the `out_w × out_h` result image from the read port of `mem_out` in row-major order. It emits the pixels as a valid/ready byte stream with a last-beat marker and a running 16-bit checksum. The stream feeds the host/UART/display export path, so SEQ and SIMD4 results can be compared outside the hierarchy.

## Interface
Parameters:
- `AW`, 12, `mem_out` address width; image capacity 2^AW pixels.
- `DW`, 8, pixel width.

Ports:
- `clk_50`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; samples `out_w`/`out_h`; ignored while `busy`.
- `out_w`  in  16  output image width, from the core's `out_w_s_*`.
- `out_h`  in  16  output image height.
- `rd_en`  out  1  read strobe to the `mem_out` read port.
- `rd_addr`  out  AW  read address.
- `rd_data`  in  DW  read data; valid exactly one cycle after the matching `rd_en`.
- `m_valid`  out  1  stream data valid.
- `m_data`  out  DW  pixel.
- `m_last`  out  1  high with the final pixel.
- `m_ready`  in  1  sink accept.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse after the final handshake.
- `checksum`  out  16  sum of transmitted pixels, mod 2^16.
- `err_size`  out  1  sticky: requested size exceeded 2^AW.

## Operation
- States:
  - IDLE: `start` → LOAD.
  - LOAD: one cycle, latches N. If N=0 → DONE, else → STREAM.
  - STREAM: after the handshake with `m_last` → DONE.
  - DONE: one cycle, `done`=1 → IDLE.
- Pixel count: N = `out_w`*`out_h`, computed in a 32-bit product.
  - If the product exceeds 2^AW, N = 2^AW and `err_size`=1.
  - `err_size` and `checksum` are cleared on an accepted `start`.
- Addresses run linearly 0..N-1, so address = y·out_w + x.
- Internal 3-entry FIFO holds `rd_data`. `m_valid` = FIFO not empty; `m_data`/`m_last` come from the FIFO head.
- Read issue rule: `rd_en`=1 in STREAM iff reads remaining > 0 and (FIFO occupancy + in-flight read) < 3.
  - In-flight read = `rd_en` of the previous cycle.
  - This rule guarantees the FIFO never overflows.
- `rd_data` is written into the FIFO at the end of the cycle in which it is valid.
- A pop happens on `m_valid && m_ready`. Push and pop in the same cycle are both performed.
- `m_last` is tagged on the entry whose read address was N-1.
- `checksum` += `m_data`, zero-extended, on each handshake; wraps mod 2^16.
- `start` while `busy`: ignored, no state change.
- `rst` mid-operation: all outputs and state return to reset values on the next edge. FIFO and in-flight read data are dropped. A following `start` restarts at address 0.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, `checksum`=0, `err_size`=0.
- Cycle 0 = the `start` cycle.
  - Cycle 1: first `rd_en` (address 0).
  - Cycle 2: `rd_data` valid.
  - Cycle 3: first `m_valid`.
- With `m_ready` held 1, throughput is 1 pixel/cycle. Beats occur in cycles 3..N+2, and `done` pulses in cycle N+3.
- N=0: `done` pulses in cycle 2. No `rd_en`, no `m_valid`.
- `m_valid`/`m_data`/`m_last` hold stable while `m_valid && !m_ready`.
- `busy` is low in the cycle after `done`, and a new `start` is accepted then.

## Test plan
- 10×10, `mem_out[i]`=i, `m_ready`=1 → 100 beats carrying 0..99 in cycles 3..102; `m_last` only on value 99; `done` in cycle 103; `checksum`=0x1356.
- Same image, `m_ready` toggling 1,0 every cycle → identical data order with no drop or duplicate. Occupancy + in-flight ≤ 3 always; `rd_addr` never issued beyond 99.
- `out_w`=0, `out_h`=10 → `done` in cycle 2, no `rd_en`, no `m_valid`, `checksum`=0, `err_size`=0.
- `out_w`=100, `out_h`=100, AW=12 → `err_size`=1, exactly 4096 beats, `m_last` on address 4095.
- 8×8 output (10×10 input at scale 205), `mem_out` all 0xFF → 64 beats, `checksum`=0x3FC0.
- Second `start` at beat 20 → ignored. Then `rst` at beat 40 → all outputs at reset values next cycle. New `start` with 10×10 → stream restarts at pixel 0, `checksum`=0x1356.
